dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core. It consumes the memory request the decode/control stage raises (memren/memwren, funct3, address, store data) and serves it from an internal word-addressed array. It applies byte-lane strobes on stores and sign/zero extension on loads, and returns one response pulse per accepted request after a fixed, parameterised read latency. It sits between execute (address generation) and writeback (wbsel = memory).

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and RV32I load/store encodings for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} dmem_size_e;

    // funct3[2] only selects sign for loads; the low two bits carry the size.
    function automatic dmem_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and load extension
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [DWIDTH-1:0] rword_i,
    output logic [3:0]        be_o,
    output logic [DWIDTH-1:0] wword_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              misalign_o
);

    dmem_size_e  size;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign size   = size_of(funct3_i);
    assign lane_b = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Replicating store data puts it on every lane; the byte enables pick the live ones.
    always_comb begin
        be_o       = 4'b1111;
        wword_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = 1'b0;
        case (size)
            BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = funct3_i[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                misalign_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory serving core load/store requests
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] ld_q, ld_d, rdata_q, rdata_d;
    logic              ready_q, ready_d, rsp_valid_q, rsp_valid_d, err_q, err_d;

    logic [AW-1:0]     widx;
    logic [DWIDTH-1:0] rword, wword, ext;
    logic [3:0]        be;
    logic              misalign, legal_ld, legal_st, req_err, accept, is_load, do_store;
    logic              unused_addr_hi;

    assign widx           = addr_i[AW+1:2];
    assign rword          = mem_q[widx];
    assign unused_addr_hi = ^addr_i[DWIDTH-1:AW+2];

    dmem_lane_align #(.DWIDTH(DWIDTH)) u_align (
        .funct3_i   (funct3_i),
        .addr_lo_i  (addr_i[1:0]),
        .wdata_i    (wdata_i),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ext),
        .misalign_o (misalign)
    );

    assign legal_ld = funct3_i inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    assign legal_st = funct3_i inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
    assign req_err  = (memren_i && memwren_i) || (memren_i && !legal_ld)
                   || (memwren_i && !legal_st) || misalign;
    // Requests carrying neither enable are dropped without leaving IDLE.
    assign accept   = req_valid_i && ready_q && (memren_i || memwren_i);
    assign is_load  = memren_i && !memwren_i;
    assign do_store = accept && memwren_i && !req_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ld_q        <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_q        <= ld_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err || !is_load || LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        ld_d = ld_q;
        if (accept) ld_d = (req_err || !is_load) ? '0 : ext;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rdata_d     = (state_d == RESP) ? ld_d : rdata_q;
        err_d       = accept && req_err;
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks against a byte-array memory model
module tb_dmem_responder;

    localparam int LAT    = 1;
    localparam int DEPTH  = 1024;
    localparam int MBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, memren_i, memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        rsp_valid_o, err_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_m [MBYTES];
    logic [31:0] got;

    always #5 clk = ~clk;

    dmem_responder #(.DWIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .memren_i    (memren_i),
        .memwren_i   (memwren_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit ren, input bit wen, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (ren && wen) return 1'b1;
        if (wen && f3 > 3'd2) return 1'b1;
        if (ren && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        sz = 1 << (f3 % 4);
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz, a;
        logic [31:0] v;
        sz = 1 << (f3 % 4);
        a  = int'(addr % MBYTES);
        v  = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[a + i];
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int sz, a;
        sz = 1 << (f3 % 4);
        a  = int'(addr % MBYTES);
        for (int i = 0; i < sz; i++) mem_m[a + i] = wd[8*i +: 8];
    endtask

    // Called and returns at a falling edge; checks latency, err, data and the return to IDLE.
    task automatic do_op(input bit ren, input bit wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        int n, lat, exp_lat;
        bit exp_err;
        logic [31:0] exp_rd;
        logic g_err;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; memren_i = ren; memwren_i = wen;
        funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        exp_err = model_err(ren, wen, f3, addr);
        exp_rd  = (!exp_err && ren) ? model_load(f3, addr) : 32'd0;
        exp_lat = (!exp_err && ren) ? 1 + LAT : 1;
        if (!exp_err && wen) model_store(f3, addr, wd);
        lat = 0; rd = '0; g_err = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid_o) begin lat = k; rd = rdata_o; g_err = err_o; break; end
        end
        chk($sformatf("latency f3=%0d a=%h", f3, addr), lat, exp_lat);
        chk($sformatf("err f3=%0d a=%h", f3, addr), {31'd0, g_err}, {31'd0, exp_err});
        chk($sformatf("rdata f3=%0d a=%h", f3, addr), rd, exp_rd);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);
        chk("ready_after_rsp", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int seen, kind;
        logic [2:0] f3;
        logic [2:0] ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n = 1'b0; req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = '0; addr_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("ready_one_edge_after", {31'd0, req_ready_o}, 32'd1);
        chk("rsp_after_release", {31'd0, rsp_valid_o}, 32'd0);

        for (int w = 0; w < 64; w++) do_op(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, got);

        do_op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, got);
        chk("sw_rdata_zero", got, 32'd0);
        do_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);
        chk("lw_deadbeef", got, 32'hDEAD_BEEF);

        do_op(1'b0, 1'b1, 3'd2, 32'h20, 32'h80FF_7F01, got);
        do_op(1'b1, 1'b0, 3'd0, 32'h23, 32'h0, got);
        chk("lb_23", got, 32'hFFFF_FF80);
        do_op(1'b1, 1'b0, 3'd4, 32'h23, 32'h0, got);
        chk("lbu_23", got, 32'h0000_0080);
        do_op(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, got);
        chk("lh_22", got, 32'hFFFF_80FF);
        do_op(1'b1, 1'b0, 3'd5, 32'h20, 32'h0, got);
        chk("lhu_20", got, 32'h0000_7F01);

        do_op(1'b0, 1'b1, 3'd2, 32'h20, 32'h0, got);
        do_op(1'b0, 1'b1, 3'd0, 32'h21, 32'h1234_56AA, got);
        do_op(1'b0, 1'b1, 3'd1, 32'h22, 32'hABCD_1234, got);
        do_op(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, got);
        chk("subword_merge", got, 32'h1234_AA00);

        do_op(1'b1, 1'b0, 3'd2, 32'h02, 32'h0, got);
        do_op(1'b1, 1'b0, 3'd2, 32'h00, 32'h0, got);
        do_op(1'b1, 1'b1, 3'd2, 32'h10, 32'h5555_5555, got);
        do_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);
        chk("both_set_no_write", got, 32'hDEAD_BEEF);

        req_valid_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h10;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
            chk("neither_ready", {31'd0, req_ready_o}, 32'd1);
        end
        req_valid_i = 1'b0;
        chk("neither_no_rsp", seen, 0);

        do_op(1'b0, 1'b1, 3'd2, 32'h1000, 32'hCAFE_F00D, got);
        do_op(1'b1, 1'b0, 3'd2, 32'h0000, 32'h0, got);
        chk("addr_wrap", got, 32'hCAFE_F00D);

        for (int r = 0; r < 80; r++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) f3 = ld_f3[$urandom_range(0, 4)];
            else          f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            do_op(kind < 5 || kind == 9, kind >= 5, f3,
                  32'(($urandom_range(0, 3) << 12) | $urandom_range(0, 255)), $urandom, got);
        end

        req_valid_i = 1'b1; memren_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h10;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; memren_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready_o}, 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        seen = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid_o) seen++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (rsp_valid_o) seen++; end
        chk("abort_no_rsp", seen, 0);
        chk("abort_ready_back", {31'd0, req_ready_o}, 32'd1);
        do_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
